// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Shared types and widths for the serial-bus responder.
//  Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Frame field widths on the serial bus
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int ID_W   = 4;

  // Bit counter width; large enough to count the 16-bit address phase
  localparam int CNT_W  = 4;

  // Responder protocol states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    AACK1    = 3'd2,
    AACK2    = 3'd3,
    WDATA    = 3'd4,
    WACK     = 3'd5,
    RDATA    = 3'd6,
    WAIT_END = 3'd7
  } bus_slave_state_t;

endpackage
`default_nettype wire

// File: rtl/slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : slave_mem
//  Purpose  : 2^MEM_AW x 8 local register file. Synchronous write,
//             combinational read, synchronous active-low clear of every byte.
//  Revision : 1.0 - initial release
// ============================================================================
module slave_mem
  import bus_pkg::*;
#(
  parameter int MEM_AW = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [MEM_AW-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte storage: clear all bytes on reset, otherwise single-byte write
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/bus_slave.sv
`default_nettype none
// ============================================================================
//  Module   : bus_slave
//  Purpose  : Target end of the bit-serial bus. Receives a 16-bit address
//             and R/W flag, matches ADDR[15:12] against SLAVE_ID, then either
//             accepts a write byte into local memory or shifts a read byte
//             out. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_slave
  import bus_pkg::*;
#(
  parameter logic [ID_W-1:0] SLAVE_ID = 4'd1,
  parameter int              MEM_AW   = 6
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic B_UTIL,
  input  logic B_RW,
  input  logic B_BUS_IN,
  output logic B_BUS_OUT,
  output logic B_ACK,
  output logic S_BSY
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  bus_slave_state_t  state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wsr_q;
  logic [DATA_W-1:0] rsr_q;
  logic              ack_q;
  logic              out_q;
  logic              bsy_q;

  // Next values of the two serial-in shift registers
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wsr_d;
  logic              id_match;
  logic              abort;

  // Memory interface
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign addr_d   = {addr_q[ADDR_W-2:0], B_BUS_IN};
  assign wsr_d    = {wsr_q[DATA_W-2:0], B_BUS_IN};

  // The ID is judged on the address as it will look once bit 0 is shifted in
  assign id_match = (addr_d[ADDR_W-1:ADDR_W-ID_W] == SLAVE_ID);

  // Frame-valid dropping mid-transaction abandons the frame
  assign abort    = !B_UTIL && (state_q != IDLE) && (state_q != WAIT_END);

  // The last write-data bit arrives on the 7th WDATA edge; the byte is
  // committed on that same edge using the not-yet-registered shift value
  assign mem_we   = RSTN && B_UTIL && (state_q == WDATA) && (cnt_q == 4'd7);

  // --------------------------------------------------------------------------
  // Local byte memory; only the low MEM_AW address bits index it, so the
  // bits between MEM_AW and the ID field alias
  // --------------------------------------------------------------------------
  slave_mem #(
    .MEM_AW (MEM_AW)
  ) u_mem (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .we_i    (mem_we),
    .waddr_i (addr_q[MEM_AW-1:0]),
    .wdata_i (wsr_d),
    .raddr_i (addr_q[MEM_AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Protocol FSM with bit counter, shift registers and registered outputs
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wsr_q   <= '0;
      rsr_q   <= '0;
      ack_q   <= 1'b0;
      out_q   <= 1'b0;
      bsy_q   <= 1'b0;
    end else if (abort) begin
      // Partial byte is discarded; no ACK follows
      state_q <= IDLE;
      cnt_q   <= '0;
      wsr_q   <= '0;
      ack_q   <= 1'b0;
      out_q   <= 1'b0;
      bsy_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edge 0: first address bit and the R/W flag arrive together
          if (B_UTIL) begin
            addr_q  <= {{(ADDR_W-1){1'b0}}, B_BUS_IN};
            rw_q    <= B_RW;
            cnt_q   <= 4'd1;
            state_q <= ADDR;
            bsy_q   <= 1'b1;
          end
        end

        ADDR: begin
          addr_q <= addr_d;
          if (cnt_q == 4'd15) begin
            cnt_q <= '0;
            if (id_match) begin
              state_q <= AACK1;
              ack_q   <= 1'b1;
            end else begin
              state_q <= WAIT_END;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        AACK1: begin
          state_q <= AACK2;
          ack_q   <= 1'b1;
        end

        AACK2: begin
          // The data phase starts on this edge: the master's first write bit
          // is already valid, and the first read bit must be on the wire in
          // the following cycle
          if (rw_q) begin
            wsr_q   <= {{(DATA_W-1){1'b0}}, B_BUS_IN};
            cnt_q   <= 4'd1;
            state_q <= WDATA;
          end else begin
            rsr_q   <= mem_rdata;
            out_q   <= mem_rdata[DATA_W-1];
            cnt_q   <= '0;
            state_q <= RDATA;
          end
        end

        WDATA: begin
          wsr_q <= wsr_d;
          if (cnt_q == 4'd7) begin
            cnt_q   <= '0;
            state_q <= WACK;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        WACK: begin
          state_q <= WAIT_END;
        end

        RDATA: begin
          rsr_q <= {rsr_q[DATA_W-2:0], 1'b0};
          if (cnt_q == 4'd7) begin
            cnt_q   <= '0;
            state_q <= WAIT_END;
          end else begin
            out_q <= rsr_q[DATA_W-2];
            cnt_q <= cnt_q + 4'd1;
          end
        end

        WAIT_END: begin
          // The master must release frame-valid before a new frame starts
          if (!B_UTIL) begin
            state_q <= IDLE;
            bsy_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Bits that shift out of the registers without ever being observed
  logic unused_bits;
  assign unused_bits = ^{addr_q[ADDR_W-1], rsr_q[DATA_W-1]};

  assign B_BUS_OUT = out_q;
  assign B_ACK     = ack_q;
  assign S_BSY     = bsy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_slave
//  Purpose  : Self-checking bench for bus_slave. An edge-indexed frame model
//             predicts B_ACK / B_BUS_OUT / S_BSY every cycle; directed frames
//             add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_slave;

  localparam int MEM_AW = 6;

  logic CLK;
  logic RSTN;
  logic B_UTIL;
  logic B_RW;
  logic B_BUS_IN;
  logic B_BUS_OUT;
  logic B_ACK;
  logic S_BSY;

  int checks = 0;
  int errors = 0;

  bus_slave #(
    .SLAVE_ID (4'd1),
    .MEM_AW   (MEM_AW)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .B_UTIL    (B_UTIL),
    .B_RW      (B_RW),
    .B_BUS_IN  (B_BUS_IN),
    .B_BUS_OUT (B_BUS_OUT),
    .B_ACK     (B_ACK),
    .S_BSY     (S_BSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Frame model: counts edges since the frame started (edge 0 = first edge
  // with B_UTIL high while idle) and derives outputs from the edge number.
  // --------------------------------------------------------------------------
  int          m_e     = -1;
  bit          m_wait  = 1'b0;
  bit          m_match = 1'b0;
  logic        m_rw    = 1'b0;
  logic [15:0] m_a     = '0;
  logic [7:0]  m_d     = '0;
  logic [7:0]  m_rd    = '0;
  logic [7:0]  mmem [2**MEM_AW];
  logic        exp_ack = 1'b0;
  logic        exp_out = 1'b0;
  logic        exp_bsy = 1'b0;

  always @(posedge CLK) begin
    if (!RSTN) begin
      m_e = -1; m_wait = 1'b0; m_match = 1'b0;
      for (int i = 0; i < 2**MEM_AW; i++) mmem[i] = 8'h00;
    end else if (m_e < 0) begin
      if (B_UTIL) begin
        m_e = 0; m_a = {15'd0, B_BUS_IN}; m_rw = B_RW; m_match = 1'b0;
      end
    end else if (m_wait) begin
      if (!B_UTIL) begin m_e = -1; m_wait = 1'b0; end
    end else if (!B_UTIL) begin
      m_e = -1;
    end else begin
      m_e++;
      if (m_e <= 15) m_a = {m_a[14:0], B_BUS_IN};
      if (m_e == 15) begin
        m_match = (m_a[15:12] == 4'd1);
        if (!m_match) m_wait = 1'b1;
      end
      if (m_rw && m_e >= 17 && m_e <= 24) m_d = {m_d[6:0], B_BUS_IN};
      if (m_rw && m_e == 24) mmem[m_a[MEM_AW-1:0]] = m_d;
      if (!m_rw && m_e == 17) m_rd = mmem[m_a[MEM_AW-1:0]];
      if (m_e == 25) m_wait = 1'b1;
    end
    exp_bsy = (m_e >= 0);
    exp_ack = exp_bsy && m_match && (m_e == 15 || m_e == 16 || (m_rw && m_e == 24));
    exp_out = (exp_bsy && m_match && !m_rw && m_e >= 17 && m_e <= 24) ? m_rd[24 - m_e] : 1'b0;
  end

  // Per-cycle comparison on the falling edge
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("cyc_ack", int'(B_ACK), int'(exp_ack));
      chk("cyc_out", int'(B_BUS_OUT), int'(exp_out));
      chk("cyc_bsy", int'(S_BSY), int'(exp_bsy));
    end
  end

  // --------------------------------------------------------------------------
  // Frame driver. stop_edge >= 0 ends the frame before that edge, either by
  // dropping B_UTIL (abort) or by asserting RSTN=0 (reset); it then returns
  // right after that edge.
  // --------------------------------------------------------------------------
  task automatic frame(input logic [15:0] a, input logic rw, input logic [7:0] d,
                       input int stop_edge, input bit stop_is_reset,
                       output logic [7:0] rb, output int acks, output logic bsy_end);
    rb = 8'h00; acks = 0; bsy_end = 1'b0;
    for (int k = 0; k < 26; k++) begin
      @(negedge CLK);
      if (k == stop_edge) begin
        B_UTIL = 1'b0;
        if (stop_is_reset) RSTN = 1'b0;
        @(posedge CLK); #1;
        return;
      end
      B_UTIL = 1'b1;
      B_RW   = (k == 0) ? rw : 1'($urandom_range(0, 1));
      if (k <= 15)                        B_BUS_IN = a[15 - k];
      else if (rw && k >= 17 && k <= 24)  B_BUS_IN = d[24 - k];
      else                                B_BUS_IN = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      if (k >= 17 && k <= 24) rb[24 - k] = B_BUS_OUT;
      acks += int'(B_ACK);
      if (k == 25) bsy_end = S_BSY;
    end
    @(negedge CLK);
    B_UTIL   = 1'b0;
    B_BUS_IN = 1'($urandom_range(0, 1));
    @(posedge CLK); #1;
  endtask

  logic [7:0] rb;
  int         acks;
  logic       be;

  initial begin
    RSTN = 1'b0; B_UTIL = 1'b0; B_RW = 1'b0; B_BUS_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ack", int'(B_ACK), 0);
    chk("rst_out", int'(B_BUS_OUT), 0);
    chk("rst_bsy", int'(S_BSY), 0);
    @(negedge CLK); RSTN = 1'b1;

    // Write match
    frame(16'h1005, 1'b1, 8'hAD, -1, 1'b0, rb, acks, be);
    chk("wr_acks", acks, 3);
    chk("wr_bsy_end", int'(be), 1);
    chk("model_mem5_ad", int'(mmem[5]), 8'hAD);

    // Read back
    frame(16'h1005, 1'b0, 8'h00, -1, 1'b0, rb, acks, be);
    chk("rd_data", int'(rb), 8'hAD);
    chk("rd_acks", acks, 2);

    // ID mismatch
    frame(16'h2005, 1'b1, 8'hFF, -1, 1'b0, rb, acks, be);
    chk("mm_acks", acks, 0);
    chk("mm_out", int'(rb), 0);
    chk("mm_bsy_end", int'(be), 1);
    frame(16'h1005, 1'b0, 8'h00, -1, 1'b0, rb, acks, be);
    chk("mm_readback", int'(rb), 8'hAD);

    // Abort after the 4th data bit (edges 17..20 sampled, drop at 21)
    frame(16'h1005, 1'b1, 8'h55, 21, 1'b0, rb, acks, be);
    chk("ab_bsy", int'(S_BSY), 0);
    chk("ab_ack", int'(B_ACK), 0);
    chk("ab_acks", acks, 2);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("ab_no_ack", int'(B_ACK), 0);
    end
    frame(16'h1005, 1'b0, 8'h00, -1, 1'b0, rb, acks, be);
    chk("ab_readback", int'(rb), 8'hAD);

    // Alias: 0x1045 and 0x1005 share byte 5
    frame(16'h1045, 1'b1, 8'h3C, -1, 1'b0, rb, acks, be);
    chk("al_acks", acks, 3);
    chk("model_mem5_3c", int'(mmem[5]), 8'h3C);
    frame(16'h1005, 1'b0, 8'h00, -1, 1'b0, rb, acks, be);
    chk("al_readback", int'(rb), 8'h3C);

    // Reset at the 3rd RDATA edge (edge 20); bits 7,6,5 of 0x3C seen first
    frame(16'h1005, 1'b0, 8'h00, 20, 1'b1, rb, acks, be);
    chk("rs_partial", int'(rb), 8'h20);
    chk("rs_ack", int'(B_ACK), 0);
    chk("rs_out", int'(B_BUS_OUT), 0);
    chk("rs_bsy", int'(S_BSY), 0);
    @(negedge CLK); RSTN = 1'b1;
    frame(16'h1005, 1'b0, 8'h00, -1, 1'b0, rb, acks, be);
    chk("rs_readback", int'(rb), 8'h00);
    chk("rs_rd_acks", acks, 2);

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_slave.md
# bus_slave

Serial-bus responder: the target end of the bit-serial bus driven by the bus master. It receives a 16-bit address and R/W flag from the granted master, decodes its 4-bit slave ID, and then either accepts 8 write-data bits into a local byte memory or returns 8 read-data bits on its serial output. It sits between the arbiter-controlled shared bus lines and a small local register memory.

## Interface

Parameters:
- SLAVE_ID, 4'd1, value matched against ADDR[15:12].
- MEM_AW, 6, local memory address width, giving 2^MEM_AW bytes. Legal range is 1..12.

Ports:
- CLK, in, 1, single clock; everything is rising-edge.
- RSTN, in, 1. Reset is synchronous and active-low.
- B_UTIL, in, 1, frame-valid from the master; high for the whole transaction.
- B_RW, in, 1, 1 = write, 0 = read; sampled with the first address bit.
- B_BUS_IN, in, 1, serial address/write data from the master, MSB first.
- B_BUS_OUT, out, 1, serial read data to the master, MSB first; 0 when not sending.
- B_ACK, out, 1, acknowledge to the master.
- S_BSY, out, 1, high whenever state ≠ IDLE.

## Operation

- States are IDLE, ADDR, AACK1, AACK2, WDATA, WACK, RDATA and WAIT_END.
- IDLE:
  - Wait for B_UTIL=1.
  - On the first edge with B_UTIL=1, capture address bit 15 and B_RW, then go to ADDR.
- ADDR:
  - Shift B_BUS_IN into the address register on each edge, capturing 16 bits total (edges 0..15, MSB first).
  - After bit 0, compare ADDR[15:12] with SLAVE_ID.
  - On match go to AACK1; on mismatch go to WAIT_END.
- AACK1 and AACK2: B_ACK=1 in both.
  - At the AACK2 edge in a read, load the read shift register from mem[ADDR[MEM_AW-1:0]].
  - Then go to WDATA if the frame is a write, or RDATA if it is a read.
- WDATA:
  - Shift 8 bits of B_BUS_IN, MSB first.
  - On the 8th bit edge, write the byte to mem[ADDR[MEM_AW-1:0]] and go to WACK.
- WACK: B_ACK=1 for one cycle, then go to WAIT_END.
- RDATA:
  - B_BUS_OUT = read shift register MSB, shifting left each edge, for 8 cycles.
  - Then go to WAIT_END.
- WAIT_END: stay until B_UTIL=0, then go to IDLE. B_ACK=0 and B_BUS_OUT=0 here.
- Address decoding:
  - Only ADDR[MEM_AW-1:0] indexes memory.
  - ADDR[11:MEM_AW] is ignored, so the memory aliases across that range.
- Abort: B_UTIL=0 sampled in any state other than IDLE or WAIT_END sends the block to IDLE on that edge.
  - There is no memory write and no ACK afterwards.
  - A partially shifted byte is discarded.
- Back-to-back frames: from WAIT_END, B_UTIL must be low for at least one edge before the next frame can start.
- B_BUS_IN and B_RW are ignored outside the states that sample them. A B_BUS_IN value of X or Z while it is not being sampled has no effect.

## Timing

- Reset: at an edge with RSTN=0, go to IDLE and clear B_ACK, B_BUS_OUT, S_BSY, the shift registers and all memory bytes to 0. This applies mid-transaction too; an in-flight write is dropped.
- All outputs are registered (Moore). No combinational path runs from any input to any output.
- Edge numbering: edge 0 is the first edge with B_UTIL=1 in IDLE.
- Address phase: bits are sampled at edges 0..15. B_ACK is high in the two cycles after edges 15 and 16.
- Write: data bits are sampled at edges 17..24. The memory is updated at edge 24. B_ACK is high in the one cycle after edge 24.
- Read: B_BUS_OUT carries bit 7 in the cycle after edge 17 and bit 0 in the cycle after edge 24. It returns to 0 after edge 25.
- Total frame (match): 26 edges with B_UTIL high for either a read or a write.

## Structure

- Package bus_pkg:
  - state enum bus_slave_state_t.
  - localparams ADDR_W=16, DATA_W=8, ID_W=4.
- Sub-module slave_mem: a 2^MEM_AW × 8 register file with synchronous write, combinational read, and synchronous active-low clear.
- Top level: FSM, bit counter (4 bits), address shift register, data shift register.

## Test plan

- Write match: SLAVE_ID=1, frame address 0x1005, B_RW=1, data 0xAD.
  - B_ACK high after edges 15–16 and after edge 24.
  - mem[5]=0xAD.
- Read back: address 0x1005, B_RW=0.
  - B_ACK high for two cycles.
  - B_BUS_OUT then shows 1,0,1,0,1,1,0,1 over 8 cycles, then 0.
- ID mismatch: write 0x2005, data 0xFF.
  - B_ACK never asserts and B_BUS_OUT stays 0.
  - S_BSY stays high until B_UTIL drops.
  - mem[5] stays 0xAD.
- Abort: write 0x1005 with B_UTIL dropped after the 4th data bit.
  - Next cycle S_BSY=0.
  - mem[5] unchanged and no further B_ACK.
- Reset mid-read: RSTN=0 at the 3rd RDATA edge.
  - After that edge all outputs are 0 and the state is IDLE.
  - A subsequent read of 0x1005 returns 0x00.
- Alias (MEM_AW=6): write 0x1045 with data 0x3C, then read 0x1005; the read returns 0x3C.
